// File: rtl/irq_input_pio_if.sv
// irq_input_pio_if: Avalon-MM slave bus plus interrupt line of the interrupt input PIO.
interface irq_input_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
endinterface

// File: rtl/irq_input_pio.sv
// irq_input_pio: synchronised, optionally debounced input PIO with per-bit W1C edge capture
// and a maskable edge- or level-mode interrupt.
module irq_input_pio #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_MODE       = 1,
   parameter int IRQ_MODE        = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   irq_input_pio_if.slave   bus
);
   localparam int WW = $clog2(SYNC_STAGES + 2);
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s_last, stable, prev_q, prev_d, edge_raw, edge_det;
   logic [WIDTH-1:0] ec_q, ec_d, mask_q, mask_d, clr;
   logic [WW-1:0]    warm_q, warm_d;
   logic [31:0]      rd_q, rd_d;
   logic             warm, wr, unused_wd;

   assign s_last    = sync_q[SYNC_STAGES-1];
   assign warm      = warm_q != '0;
   assign unused_wd = ^bus.writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
         assign stable = s_last;
      end else begin : g_db
         logic [WIDTH-1:0]       stable_q, stable_d;
         logic [WIDTH-1:0][15:0] cnt_q, cnt_d;
         always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (warm) stable_d[i] = s_last[i];
               else if (s_last[i] != stable_q[i]) begin
                  if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) stable_d[i] = s_last[i];
                  else cnt_d[i] = cnt_q[i] + 16'd1;
               end
            end
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               stable_q <= '0;
               cnt_q    <= '0;
            end else begin
               stable_q <= stable_d;
               cnt_q    <= cnt_d;
            end
         end
         assign stable = stable_q;
      end
   endgenerate

   // prev tracks the raw synchronised value during warm-up so no edge appears when it ends
   assign prev_d   = warm ? s_last : stable;
   assign edge_raw = EDGE_MODE == 0 ? (stable & ~prev_q) :
                     EDGE_MODE == 1 ? (~stable & prev_q) : (stable ^ prev_q);
   assign edge_det = warm ? '0 : edge_raw;
   assign wr       = bus.chipselect & ~bus.write_n;
   assign clr      = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
   assign ec_d     = edge_det | (ec_q & ~clr);
   assign mask_d   = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
   assign warm_d   = warm ? warm_q - WW'(1) : warm_q;
   assign rd_d     = bus.address == 2'd0 ? 32'(stable) :
                     bus.address == 2'd2 ? 32'(mask_q) :
                     bus.address == 2'd3 ? 32'(ec_q) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         warm_q <= WW'(SYNC_STAGES + 1);
         prev_q <= '0;
         ec_q   <= '0;
         mask_q <= '0;
         rd_q   <= '0;
      end else begin
         warm_q <= warm_d;
         prev_q <= prev_d;
         ec_q   <= ec_d;
         mask_q <= mask_d;
         rd_q   <= rd_d;
      end
   end

   assign bus.readdata = rd_q;
   assign bus.irq      = IRQ_MODE == 1 ? |(stable & mask_q) : |(ec_q & mask_q);
endmodule

// File: tb/tb_irq_input_pio.sv
// tb_irq_input_pio: directed bench over three builds (falling/edge, debounced, any-edge/level)
// with a queue of expected results checked as each DUT output appears.
module tb_irq_input_pio;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] addr = '0;
   logic [2:0] cs = '0;
   logic       wn = 1'b1;
   logic [31:0] wd = '0;
   logic [7:0] in_a = 8'hFF, in_b = 8'hFF, in_c = 8'h00;
   logic [31:0] rd_v [3];
   logic       irq_v [3];
   int         n_cmp = 0, n_err = 0;

   typedef struct {string tag; int d; bit is_irq; logic [31:0] e;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   irq_input_pio_if bus_a ();
   irq_input_pio_if bus_b ();
   irq_input_pio_if bus_c ();

   assign bus_a.address = addr;  assign bus_a.chipselect = cs[0];
   assign bus_a.write_n = wn;    assign bus_a.writedata  = wd;
   assign bus_b.address = addr;  assign bus_b.chipselect = cs[1];
   assign bus_b.write_n = wn;    assign bus_b.writedata  = wd;
   assign bus_c.address = addr;  assign bus_c.chipselect = cs[2];
   assign bus_c.write_n = wn;    assign bus_c.writedata  = wd;
   assign rd_v[0] = bus_a.readdata;  assign irq_v[0] = bus_a.irq;
   assign rd_v[1] = bus_b.readdata;  assign irq_v[1] = bus_b.irq;
   assign rd_v[2] = bus_c.readdata;  assign irq_v[2] = bus_c.irq;

   irq_input_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1), .IRQ_MODE(0))
      dut_a (.clk(clk), .reset(reset), .in_port(in_a), .bus(bus_a));
   irq_input_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .IRQ_MODE(0))
      dut_b (.clk(clk), .reset(reset), .in_port(in_b), .bus(bus_b));
   irq_input_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .IRQ_MODE(1))
      dut_c (.clk(clk), .reset(reset), .in_port(in_c), .bus(bus_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check();
      exp_t x;
      logic [31:0] obs;
      x = sb.pop_front();
      obs = x.is_irq ? {31'b0, irq_v[x.d]} : rd_v[x.d];
      n_cmp++;
      assert (obs === x.e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.e);
      end
   endtask

   task automatic chk_irq(input string tag, input int d, input logic [31:0] e);
      sb.push_back('{tag, d, 1'b1, e});
      check();
   endtask

   task automatic chk_rd(input string tag, input int d, input logic [31:0] e);
      sb.push_back('{tag, d, 1'b0, e});
      check();
   endtask

   task automatic rd(input string tag, input int d, input logic [1:0] a, input logic [31:0] e);
      addr = a;
      sb.push_back('{tag, d, 1'b0, e});
      tick();
      check();
   endtask

   task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
      addr = a;
      wd = v;
      cs[d] = 1'b1;
      wn = 1'b0;
      tick();
      cs = '0;
      wn = 1'b1;
   endtask

   initial begin
      repeat (3) tick();
      chk_rd("rst_rd_a", 0, 0);
      chk_irq("rst_irq_a", 0, 0);
      chk_irq("rst_irq_c", 2, 0);
      reset = 1'b0;
      repeat (6) tick();
      rd("a_ec_warm", 0, 3, 0);
      rd("a_data_idle", 0, 0, 32'hFF);
      rd("a_resv", 0, 1, 0);
      chk_irq("a_irq_idle", 0, 0);
      // falling edge on bit 3: capture lands on the third edge after the change
      in_a = 8'hF7;
      wr(0, 2, 32'h08);
      rd("a_ec_e2", 0, 3, 0);
      chk_irq("a_irq_e2", 0, 0);
      rd("a_ec_e3", 0, 3, 0);
      chk_irq("a_irq_e3", 0, 1);
      rd("a_ec_e4", 0, 3, 32'h08);
      rd("a_mask", 0, 2, 32'h08);
      // write-1-to-clear
      in_a = 8'hF5;
      repeat (4) tick();
      rd("a_ec_0a", 0, 3, 32'h0A);
      wr(0, 3, 32'h02);
      rd("a_w1c_02", 0, 3, 32'h08);
      chk_irq("a_irq_keep", 0, 1);
      wr(0, 3, 32'h08);
      chk_irq("a_irq_drop", 0, 0);
      rd("a_ec_clear", 0, 3, 0);
      // new edge on bit 1 coincides with a clear of bit 1
      in_a = 8'hF7;
      repeat (5) tick();
      rd("a_rise_ign", 0, 3, 0);
      in_a = 8'hF5;
      tick();
      tick();
      wr(0, 3, 32'h02);
      rd("a_simul", 0, 3, 32'h02);
      chk_irq("a_simul_irq", 0, 0);
      wr(0, 3, 32'h02);
      rd("a_simul_clr", 0, 3, 0);
      // debounce: short glitch rejected, long pulse accepted
      rd("b_data_idle", 1, 0, 32'hFF);
      chk_irq("b_irq_idle", 1, 0);
      in_b = 8'hFE;
      repeat (3) tick();
      in_b = 8'hFF;
      repeat (10) tick();
      rd("b_glitch_ec", 1, 3, 0);
      rd("b_glitch_data", 1, 0, 32'hFF);
      in_b = 8'hFE;
      repeat (5) tick();
      rd("b_data_e6", 1, 0, 32'hFF);
      rd("b_ec_e7", 1, 3, 0);
      rd("b_ec_e8", 1, 3, 32'h01);
      rd("b_data_e9", 1, 0, 32'hFE);
      tick();
      in_b = 8'hFF;
      repeat (10) tick();
      rd("b_data_back", 1, 0, 32'hFF);
      rd("b_ec_hold", 1, 3, 32'h01);
      // any-edge capture with level irq
      wr(2, 2, 32'h01);
      chk_irq("c_irq_low", 2, 0);
      in_c = 8'h01;
      tick();
      chk_irq("c_irq_e1", 2, 0);
      tick();
      chk_irq("c_irq_e2", 2, 1);
      rd("c_ec_e3", 2, 3, 0);
      rd("c_ec_rise", 2, 3, 32'h01);
      wr(2, 3, 32'h01);
      rd("c_ec_clr", 2, 3, 0);
      repeat (14) tick();
      chk_irq("c_irq_e20", 2, 1);
      in_c = 8'h00;
      tick();
      chk_irq("c_irq_e21", 2, 1);
      tick();
      chk_irq("c_irq_e22", 2, 0);
      rd("c_ec_e23", 2, 3, 0);
      rd("c_ec_fall", 2, 3, 32'h01);
      rd("c_data_low", 2, 0, 0);
      // reset mid-operation with all captures pending
      in_a = 8'hFF;
      repeat (5) tick();
      in_a = 8'h00;
      repeat (5) tick();
      wr(0, 2, 32'hFF);
      rd("d_ec_ff", 0, 3, 32'hFF);
      chk_irq("d_irq_pre", 0, 1);
      reset = 1'b1;
      in_a = 8'hFF;
      in_c = 8'h01;
      tick();
      chk_rd("d_rd_rst", 0, 0);
      chk_irq("d_irq_rst", 0, 0);
      in_a = 8'h00;
      in_c = 8'h00;
      tick();
      in_a = 8'h55;
      in_c = 8'h01;
      reset = 1'b0;
      rd("d_mask_rst", 0, 2, 0);
      rd("d_ec_rst", 0, 3, 0);
      repeat (8) tick();
      rd("d_ec_a_warm", 0, 3, 0);
      rd("d_ec_c_warm", 2, 3, 0);
      rd("d_ec_b_warm", 1, 3, 0);
      rd("d_data_a", 0, 0, 32'h55);
      chk_irq("d_irq_a", 0, 0);
      chk_irq("d_irq_c", 2, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
